// File: rtl/hk_spi_slave_if.sv
// hk_spi_slave_if: SPI pin bundle plus the single-port register bus of the
// housekeeping SPI slave. The slave modport is the block's view; the master
// modport is the view of whatever drives the SPI pins and serves the registers.
interface hk_spi_slave_if;
    // SPI pins, asynchronous to the system clock.
    logic       spi_csb;
    logic       spi_sck;
    logic       spi_sdi;
    logic       spi_sdo;

    // Register interface; reg_rdata is a combinational function of reg_addr.
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    // Transfer status.
    logic       xfer_active;

    modport slave (
        input  spi_csb,
        input  spi_sck,
        input  spi_sdi,
        input  reg_rdata,
        output spi_sdo,
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        output xfer_active
    );

    modport master (
        output spi_csb,
        output spi_sck,
        output spi_sdi,
        output reg_rdata,
        input  spi_sdo,
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        input  xfer_active
    );
endinterface

// File: rtl/hk_spi_slave.sv
// hk_spi_slave: housekeeping SPI slave, mode 0, MSB first.
// Oversamples csb/sck/sdi on clk, decodes a command / address / data byte
// protocol and drives a single-port register bus with auto-incrementing
// addresses.
//   cmd[7:6]: 10 write, 01 read, 11 read-write, 00 ignore rest of transfer.
// Optional feature macro: HK_SPI_STREAM_LIMIT_EN
//   defined   : cmd[5:3] = N (nonzero) limits the transfer to N data bytes.
//   undefined : cmd[5:3] is ignored; data streams until csb rises.
module hk_spi_slave #(
    parameter int SYNC_STAGES = 2   // legal values: 2 or 3
) (
    input  logic          clk,
    input  logic          resetn,
    hk_spi_slave_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] csb_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    // Marks which synchronizer stages hold real pin samples rather than
    // reset values, so a csb held low across reset is not taken as a fall.
    logic [SYNC_STAGES-1:0] vld_sync_q;
    logic                   csb_prev_q;
    logic                   sck_prev_q;

    logic csb_s;
    logic sck_s;
    logic sdi_s;
    logic vld_s;
    logic csb_rise;
    logic sck_rise;
    logic sck_fall;

    // Synchronizer chains plus one extra register stage for edge detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: every stage gets a defined reset value (csb idle high,
            // sck/sdi low) so no false edge is detected as reset releases.
            csb_sync_q <= '1;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            vld_sync_q <= '0;
            csb_prev_q <= 1'b1;
            sck_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the old
            // value of its neighbour; blocking ones would collapse the chain.
            csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], bus.spi_csb};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.spi_sdi};
            vld_sync_q <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
            csb_prev_q <= csb_sync_q[SYNC_STAGES-1];
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign csb_s    = csb_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign vld_s    = vld_sync_q[SYNC_STAGES-1];
    assign csb_rise =  csb_s & ~csb_prev_q;
    assign sck_rise =  sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s &  sck_prev_q;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_e      state_q,     state_d;
    logic [2:0]  bitcnt_q,    bitcnt_d;
    logic [7:0]  rx_shift_q,  rx_shift_d;
    logic [7:0]  tx_shift_q,  tx_shift_d;
    logic [1:0]  mode_q,      mode_d;       // cmd[7:6]: [1] write, [0] read
    logic [7:0]  reg_addr_q,  reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic        reg_we_q,    reg_we_d;
    logic        reg_re_q,    reg_re_d;
    logic        inc_pend_q,  inc_pend_d;   // address bump due in cycle E+1
    logic        xfer_act_q,  xfer_act_d;
    logic        armed_q,     armed_d;      // csb has been seen high since reset
`ifdef HK_SPI_STREAM_LIMIT_EN
    logic [2:0]  limit_q,     limit_d;      // 0 = unlimited
    logic [2:0]  bytecnt_q,   bytecnt_d;
`endif

    logic [7:0]  rx_byte;
    logic        byte_done;

    assign rx_byte   = {rx_shift_q[6:0], sdi_s};
    assign byte_done = sck_rise && (bitcnt_q == 3'd7);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            mode_q      <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            inc_pend_q  <= 1'b0;
            xfer_act_q  <= 1'b0;
            armed_q     <= 1'b0;
`ifdef HK_SPI_STREAM_LIMIT_EN
            limit_q     <= '0;
            bytecnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            mode_q      <= mode_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            inc_pend_q  <= inc_pend_d;
            xfer_act_q  <= xfer_act_d;
            armed_q     <= armed_d;
`ifdef HK_SPI_STREAM_LIMIT_EN
            limit_q     <= limit_d;
            bytecnt_q   <= bytecnt_d;
`endif
        end
    end

    // Next-state logic: FSM transitions, shift registers and register strobes.
    always_comb begin
        // NOTE: every _d signal gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        mode_d      = mode_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        inc_pend_d  = 1'b0;
        xfer_act_d  = xfer_act_q;
        armed_d     = armed_q | (vld_s & csb_s);
`ifdef HK_SPI_STREAM_LIMIT_EN
        limit_d     = limit_q;
        bytecnt_d   = bytecnt_q;
`endif

        if (csb_rise) begin
            // End of transfer wins over any sck edge in the same cycle; a
            // partial byte and any pending strobe are dropped.
            state_d    = ST_IDLE;
            bitcnt_d   = '0;
            tx_shift_d = '0;
            xfer_act_d = 1'b0;
        end else begin
            // Shifting is common to the three byte-receiving states. The fall
            // right after a byte's 8th rise does not shift, so a freshly
            // loaded read byte keeps its MSB for the next rise.
            if (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA) begin
                if (sck_rise) begin
                    rx_shift_d = rx_byte;
                    bitcnt_d   = bitcnt_q + 3'd1;
                end
                if (sck_fall && (bitcnt_q != 3'd0)) begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (armed_q && !csb_s) begin
                        state_d    = ST_CMD;
                        bitcnt_d   = '0;
                        rx_shift_d = '0;
                        tx_shift_d = '0;
                        xfer_act_d = 1'b1;
`ifdef HK_SPI_STREAM_LIMIT_EN
                        bytecnt_d  = '0;
`endif
                    end
                end

                ST_CMD: begin
                    if (byte_done) begin
                        mode_d  = rx_byte[7:6];
`ifdef HK_SPI_STREAM_LIMIT_EN
                        limit_d = rx_byte[5:3];
`endif
                        state_d = (rx_byte[7:6] == 2'b00) ? ST_IGNORE : ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (byte_done) begin
                        reg_addr_d = rx_byte;
                        reg_re_d   = mode_q[0];
                        state_d    = ST_DATA;
                    end
                end

                ST_DATA: begin
                    // The read strobe's cycle is also when reg_rdata is captured.
                    if (reg_re_q) begin
                        tx_shift_d = bus.reg_rdata;
                    end
                    if (inc_pend_q) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        reg_re_d   = mode_q[0];
                    end
                    if (byte_done) begin
                        if (mode_q[1]) begin
                            reg_we_d    = 1'b1;
                            reg_wdata_d = rx_byte;
                        end
                        inc_pend_d = 1'b1;
`ifdef HK_SPI_STREAM_LIMIT_EN
                        bytecnt_d = bytecnt_q + 3'd1;
                        if ((limit_q != 3'd0) && ((bytecnt_q + 3'd1) == limit_q)) begin
                            state_d    = ST_IGNORE;
                            inc_pend_d = 1'b0;
                        end
`endif
                    end
                end

                ST_IGNORE: begin
                    // Wait for csb to rise; sck activity is ignored.
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.spi_sdo     = (state_q == ST_DATA) && mode_q[0] && tx_shift_q[7];
    assign bus.reg_addr    = reg_addr_q;
    assign bus.reg_wdata   = reg_wdata_q;
    assign bus.reg_we      = reg_we_q;
    assign bus.reg_re      = reg_re_q;
    assign bus.xfer_active = xfer_act_q;

endmodule

// File: tb/tb_hk_spi_slave.sv
// tb_hk_spi_slave: directed bench for hk_spi_slave. Acts as SPI master and as
// a 256-byte register file whose contents start as ~addr.
`timescale 1ns/1ps
module tb_hk_spi_slave;

    localparam int SS   = 2;
    localparam int HALF = 120;   // sck half period in ns (12 clk cycles)

    logic clk;
    logic resetn;

    hk_spi_slave_if bus();

    hk_spi_slave #(.SYNC_STAGES(SS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Register file model and strobe monitor.
    logic [7:0]  mem [256];
    logic        mem_init;
    logic [15:0] we_log [$];
    logic [7:0]  re_log [$];
    int          sdo_hi_cnt;

    logic [7:0]  tx_buf [4];
    logic [7:0]  rx_buf [4];

    assign bus.reg_rdata = mem[bus.reg_addr];

    // Clock generator.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file writes and strobe logging, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= ~8'(i);
        end else if (bus.reg_we) begin
            mem[bus.reg_addr] <= bus.reg_wdata;
        end
        if (bus.reg_we) we_log.push_back({bus.reg_addr, bus.reg_wdata});
        if (bus.reg_re) re_log.push_back(bus.reg_addr);
        if (bus.spi_sdo) sdo_hi_cnt <= sdo_hi_cnt + 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    task automatic align();
        @(posedge clk); #2;
    endtask

    task automatic init_mem();
        mem_init = 1'b1;
        @(posedge clk); @(negedge clk); @(posedge clk); #2;
        mem_init = 1'b0;
    endtask

    // Shift n bits of tx out (MSB first), collecting sdo at each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            bus.spi_sdi = tx[7-i];
            #(HALF);
            bus.spi_sck = 1'b1;
            rx = {rx[6:0], bus.spi_sdo};
            #(HALF);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic start_xfer();
        bus.spi_csb = 1'b0;
        #(HALF);
    endtask

    task automatic end_xfer();
        #(HALF);
        bus.spi_csb = 1'b1;
        #(2*HALF);
    endtask

    task automatic send_bytes(input int n);
        for (int k = 0; k < n; k++) spi_bits(tx_buf[k], 8, rx_buf[k]);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (bus.spi_sdo !== 1'b0) begin mismatched++; $display("FAIL reset_sdo: got %b expected 0", bus.spi_sdo); end
        compared++; if (bus.reg_addr !== 8'h00) begin mismatched++; $display("FAIL reset_addr: got %h expected 00", bus.reg_addr); end
        compared++; if (bus.reg_wdata !== 8'h00) begin mismatched++; $display("FAIL reset_wdata: got %h expected 00", bus.reg_wdata); end
        compared++; if (bus.reg_we !== 1'b0) begin mismatched++; $display("FAIL reset_we: got %b expected 0", bus.reg_we); end
        compared++; if (bus.reg_re !== 1'b0) begin mismatched++; $display("FAIL reset_re: got %b expected 0", bus.reg_re); end
        compared++; if (bus.xfer_active !== 1'b0) begin mismatched++; $display("FAIL reset_xfer: got %b expected 0", bus.xfer_active); end
        align();
        resetn = 1'b1;
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic test_write_stream();
        int we0, re0, sdo0;
        init_mem();
        we0 = we_log.size(); re0 = re_log.size(); sdo0 = sdo_hi_cnt;
        tx_buf = '{8'h80, 8'h10, 8'hAA, 8'h55};
        start_xfer();
        compared++; if (bus.xfer_active !== 1'b1) begin mismatched++; $display("FAIL wr_xfer_active: got %b expected 1", bus.xfer_active); end
        send_bytes(4);
        end_xfer();
        compared++; if (we_log.size() - we0 != 2) begin mismatched++; $display("FAIL wr_count: got %0d expected 2", we_log.size() - we0); end
        if (we_log.size() - we0 == 2) begin
            compared++; if (we_log[we0] !== 16'h10AA) begin mismatched++; $display("FAIL wr_first: got %h expected 10AA", we_log[we0]); end
            compared++; if (we_log[we0+1] !== 16'h1155) begin mismatched++; $display("FAIL wr_second: got %h expected 1155", we_log[we0+1]); end
        end
        compared++; if (re_log.size() != re0) begin mismatched++; $display("FAIL wr_no_read: got %0d expected %0d", re_log.size(), re0); end
        compared++; if (sdo_hi_cnt != sdo0) begin mismatched++; $display("FAIL wr_sdo_low: got %0d expected %0d", sdo_hi_cnt, sdo0); end
        compared++; if (bus.xfer_active !== 1'b0) begin mismatched++; $display("FAIL wr_xfer_end: got %b expected 0", bus.xfer_active); end
    endtask

    task automatic test_read_stream();
        int we0, re0;
        init_mem();
        we0 = we_log.size(); re0 = re_log.size();
        tx_buf = '{8'h40, 8'h20, 8'h00, 8'h00};
        start_xfer();
        send_bytes(4);
        end_xfer();
        compared++; if (rx_buf[2] !== 8'hDF) begin mismatched++; $display("FAIL rd_byte0: got %h expected DF", rx_buf[2]); end
        compared++; if (rx_buf[3] !== 8'hDE) begin mismatched++; $display("FAIL rd_byte1: got %h expected DE", rx_buf[3]); end
        compared++; if (re_log.size() - re0 != 3) begin mismatched++; $display("FAIL rd_count: got %0d expected 3", re_log.size() - re0); end
        if (re_log.size() - re0 == 3) begin
            compared++;
            if ({re_log[re0], re_log[re0+1], re_log[re0+2]} !== 24'h202122) begin
                mismatched++;
                $display("FAIL rd_addrs: got %h %h %h expected 20 21 22", re_log[re0], re_log[re0+1], re_log[re0+2]);
            end
        end
        compared++; if (we_log.size() != we0) begin mismatched++; $display("FAIL rd_no_write: got %0d expected %0d", we_log.size(), we0); end
    endtask

    task automatic test_rw_wrap();
        int we0;
        init_mem();
        we0 = we_log.size();
        tx_buf = '{8'hC0, 8'hFF, 8'h12, 8'h34};
        start_xfer();
        send_bytes(4);
        end_xfer();
        compared++; if (rx_buf[2] !== 8'h00) begin mismatched++; $display("FAIL rw_old_ff: got %h expected 00", rx_buf[2]); end
        compared++; if (rx_buf[3] !== 8'hFF) begin mismatched++; $display("FAIL rw_old_00: got %h expected FF", rx_buf[3]); end
        compared++; if (we_log.size() - we0 != 2) begin mismatched++; $display("FAIL rw_count: got %0d expected 2", we_log.size() - we0); end
        if (we_log.size() - we0 == 2) begin
            compared++; if (we_log[we0] !== 16'hFF12) begin mismatched++; $display("FAIL rw_first: got %h expected FF12", we_log[we0]); end
            compared++; if (we_log[we0+1] !== 16'h0034) begin mismatched++; $display("FAIL rw_wrap: got %h expected 0034", we_log[we0+1]); end
        end
        compared++; if (bus.reg_addr !== 8'h01) begin mismatched++; $display("FAIL rw_end_addr: got %h expected 01", bus.reg_addr); end
    endtask

    task automatic test_abort();
        int we0;
        logic [7:0] dummy;
        init_mem();
        we0 = we_log.size();
        tx_buf = '{8'h80, 8'h05, 8'h00, 8'h00};
        start_xfer();
        send_bytes(2);
        spi_bits(8'hF0, 5, dummy);
        compared++; if (bus.xfer_active !== 1'b1) begin mismatched++; $display("FAIL abort_active: got %b expected 1", bus.xfer_active); end
        bus.spi_csb = 1'b1;
        repeat (SS + 2) @(posedge clk);
        #1;
        compared++; if (bus.xfer_active !== 1'b0) begin mismatched++; $display("FAIL abort_xfer: got %b expected 0", bus.xfer_active); end
        compared++; if (dut.state_q !== 3'd0) begin mismatched++; $display("FAIL abort_idle: got %0d expected 0", dut.state_q); end
        repeat (20) @(posedge clk);
        #2;
        compared++; if (we_log.size() != we0) begin mismatched++; $display("FAIL abort_no_write: got %0d expected %0d", we_log.size(), we0); end
    endtask

    task automatic test_stream_limit();
        int we0;
        init_mem();
        we0 = we_log.size();
        tx_buf = '{8'h88, 8'h30, 8'h01, 8'h02};
        start_xfer();
        send_bytes(4);
        end_xfer();
`ifdef HK_SPI_STREAM_LIMIT_EN
        compared++; if (we_log.size() - we0 != 1) begin mismatched++; $display("FAIL lim_count: got %0d expected 1", we_log.size() - we0); end
`else
        compared++; if (we_log.size() - we0 != 2) begin mismatched++; $display("FAIL lim_count: got %0d expected 2", we_log.size() - we0); end
        if (we_log.size() - we0 == 2) begin
            compared++; if (we_log[we0+1] !== 16'h3102) begin mismatched++; $display("FAIL lim_second: got %h expected 3102", we_log[we0+1]); end
        end
`endif
        if (we_log.size() - we0 >= 1) begin
            compared++; if (we_log[we0] !== 16'h3001) begin mismatched++; $display("FAIL lim_first: got %h expected 3001", we_log[we0]); end
        end
    endtask

    task automatic test_ignore();
        int we0, re0, sdo0;
        init_mem();
        we0 = we_log.size(); re0 = re_log.size(); sdo0 = sdo_hi_cnt;
        tx_buf = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        start_xfer();
        send_bytes(3);
        compared++; if (dut.state_q !== 3'd4) begin mismatched++; $display("FAIL ign_state: got %0d expected 4", dut.state_q); end
        end_xfer();
        compared++; if ((we_log.size() != we0) || (re_log.size() != re0)) begin
            mismatched++; $display("FAIL ign_no_strobe: got we %0d re %0d expected we %0d re %0d", we_log.size(), re_log.size(), we0, re0);
        end
        compared++; if (sdo_hi_cnt != sdo0) begin mismatched++; $display("FAIL ign_sdo: got %0d expected %0d", sdo_hi_cnt, sdo0); end
    endtask

    task automatic test_reset_mid_read();
        int re0;
        logic [7:0] dummy;
        init_mem();
        tx_buf = '{8'h40, 8'h50, 8'h00, 8'h00};
        start_xfer();
        send_bytes(2);
        spi_bits(8'h00, 3, dummy);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        compared++; if ({bus.spi_sdo, bus.reg_we, bus.reg_re, bus.xfer_active} !== 4'b0000) begin
            mismatched++; $display("FAIL rst_mid_ctrl: got %b expected 0000", {bus.spi_sdo, bus.reg_we, bus.reg_re, bus.xfer_active});
        end
        compared++; if ({bus.reg_addr, bus.reg_wdata} !== 16'h0000) begin
            mismatched++; $display("FAIL rst_mid_bus: got %h expected 0000", {bus.reg_addr, bus.reg_wdata});
        end
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        compared++; if (dut.state_q !== 3'd0) begin mismatched++; $display("FAIL rst_stay_idle: got %0d expected 0", dut.state_q); end
        compared++; if (bus.xfer_active !== 1'b0) begin mismatched++; $display("FAIL rst_stay_inactive: got %b expected 0", bus.xfer_active); end
        align();
        bus.spi_csb = 1'b1;
        #(2*HALF);
        re0 = re_log.size();
        tx_buf = '{8'h40, 8'h50, 8'h00, 8'h00};
        start_xfer();
        send_bytes(3);
        end_xfer();
        compared++; if (rx_buf[2] !== 8'hAF) begin mismatched++; $display("FAIL rst_reread: got %h expected AF", rx_buf[2]); end
        compared++; if ((re_log.size() - re0 < 1) || (re_log[re0] !== 8'h50)) begin
            mismatched++; $display("FAIL rst_reread_addr: got count %0d expected first read at 50", re_log.size() - re0);
        end
    endtask

    initial begin
        bus.spi_csb = 1'b1;
        bus.spi_sck = 1'b0;
        bus.spi_sdi = 1'b0;
        mem_init    = 1'b1;
        sdo_hi_cnt  = 0;
        resetn      = 1'b0;
        align();
        test_reset();
        test_write_stream();
        test_read_stream();
        test_rw_wrap();
        test_abort();
        test_stream_limit();
        test_ignore();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hk_spi_slave.md
# hk_spi_slave

Housekeeping SPI slave that sits directly downstream of the UART-to-SPI bridge and consumes its spi_csb/spi_sck/spi_sdi stream, returning spi_sdo. It oversamples the SPI lines on the system clock, decodes a command/address/data byte protocol and drives a simple single-port register interface. It also acts as the reference slave in bridge-level simulation.

## Interface
- SYNC_STAGES, 2: synchronizer depth on spi_csb, spi_sck and spi_sdi; legal values are 2 or 3.
- clk  in  1  system clock; SPI lines are sampled on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- spi_csb  in  1  chip select, active-low, asynchronous to clk.
- spi_sck  in  1  SPI clock (mode 0), asynchronous to clk.
- spi_sdi  in  1  master-to-slave data, MSB first.
- spi_sdo  out  1  slave-to-master data, MSB first.
- reg_addr  out  8  register address.
- reg_wdata  out  8  write data; valid while reg_we is high.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe; reg_rdata is sampled in the same cycle.
- reg_rdata  in  8  read data; combinational function of reg_addr.
- xfer_active  out  1  high from the synchronized csb fall until the synchronized csb rise.

## Operation
- Synchronize csb, sck and sdi through SYNC_STAGES flops, then register once more for edge detection.
- sck rise edge: shift sdi into rx_shift (LSB-in) and increment bitcnt (3 bits).
- sck fall edge: shift tx_shift left with zero fill. spi_sdo = tx_shift[7] at all times.
- FSM states are IDLE, CMD, ADDR, DATA and IGNORE.
  - IDLE: on synchronized csb low, go to CMD, clear bitcnt and tx_shift, and raise xfer_active.
  - CMD: on the 8th rise, latch cmd = rx byte.
    - cmd[7:6] = 10: write. 01: read. 11: read-write.
    - cmd[7:6] = 00: go to IGNORE.
    - Any other command goes to ADDR.
  - ADDR: on the 8th rise, latch the address into reg_addr and go to DATA. In read or read-write mode, pulse reg_re in the following cycle and load tx_shift from reg_rdata.
  - DATA, at byte end (8th rise, cycle E):
    - Write or read-write: pulse reg_we in E with reg_addr = current address and reg_wdata = rx byte.
    - In E+1, reg_addr increments by 1, wrapping 0xFF to 0x00.
    - Read or read-write: pulse reg_re in E+1 and capture reg_rdata into tx_shift in E+1.
  - IGNORE: sck is ignored and spi_sdo = 0 until csb rises.
- spi_sdo = 0 in IDLE, CMD and ADDR, and in DATA when the mode is write-only.
- csb rise in any state:
  - Return to IDLE and discard any partial byte; no reg_we or reg_re is issued.
  - Clear tx_shift and drop xfer_active.
  - csb rise takes priority over an sck edge detected in the same cycle.
- A new csb fall restarts the protocol at CMD. There is no state carry-over between transfers.

## Timing
- Reset values: spi_sdo 0, reg_addr 0x00, reg_wdata 0x00, reg_we 0, reg_re 0, xfer_active 0. FSM is in IDLE, bitcnt 0, and the synchronizers are cleared to csb=1, sck=0, sdi=0.
- Reset mid-transfer returns the block to IDLE. It re-enters CMD only after csb is seen high and then low again.
- Input-to-action latency is SYNC_STAGES+1 clk cycles from a pin edge.
- reg_we lands at latency+0 after the 8th rise. reg_re and the tx_shift load land at latency+1.
- The sck high and low phases must each be at least 2*(SYNC_STAGES+2) clk cycles. The bridge supplies about 521 cycles, which satisfies this.
- A loaded read byte is visible on spi_sdo before the next sck fall. Its MSB is therefore stable for the master's next rise-edge sample.

## Configuration
- HK_SPI_STREAM_LIMIT_EN defined: cmd[5:3] = N, nonzero, limits the transfer to N data bytes. After the Nth byte completes, the FSM goes to IGNORE. cmd[5:3] = 0 means unlimited streaming.
- HK_SPI_STREAM_LIMIT_EN undefined: cmd[5:3] is ignored and every transfer streams until csb rises.

## Test plan
- Write stream:
  - Stimulus: csb low, send 0x80, 0x10, 0xAA, 0x55, then csb high.
  - Response: reg_we pulses twice, with (0x10, 0xAA) then (0x11, 0x55). No reg_re. spi_sdo stays 0.
- Read stream:
  - Setup: the model returns ~addr.
  - Stimulus: send 0x40, 0x20, then two dummy bytes.
  - Response: the master samples 0xDF, then 0xDE. reg_re pulses at addresses 0x20, 0x21 and 0x22.
- Read-write with wrap:
  - Stimulus: send 0xC0, 0xFF, 0x12, 0x34.
  - Response: writes go to (0xFF, 0x12) and (0x00, 0x34). Readback bytes are the old contents of 0xFF and 0x00. reg_addr is 0x01 at the end.
- Abort:
  - Stimulus: send 0x80 and 0x05, then raise csb after 5 bits of the data byte.
  - Response: no reg_we. FSM is in IDLE and xfer_active is 0 within SYNC_STAGES+2 cycles.
- With HK_SPI_STREAM_LIMIT_EN:
  - Stimulus: send 0x88 (N=1), 0x30, 0x01, 0x02.
  - Response: a single write (0x30, 0x01); the second byte is ignored.
  - Without the macro: two writes.
- Reset mid-read:
  - Stimulus: assert resetn=0 during a DATA byte.
  - Response: all outputs return to their reset values on the next clk. The next full 0x40 transfer reads correctly.
